// File: rtl/exec_issue_ctl.sv
// Execute-stage issue/control: RAW scoreboard, flag register, jump resolution and
// the registered control word for the next stage. Optional macro EXEC_FWD_EN enables writeback forwarding.
module exec_issue_ctl #(
  parameter int REGNO    = 8,
  parameter int SB_DEPTH = 2,
  parameter int FLAG_CNT = 5,
  parameter int JC_W     = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_submit,
  input  logic                     i_flush,
  output logic                     o_ready,
  input  logic [$clog2(REGNO)-1:0] c_l_sel,
  input  logic [$clog2(REGNO)-1:0] c_r_sel,
  input  logic                     c_l_use,
  input  logic                     c_r_use,
  input  logic [REGNO-1:0]         c_rf_ie,
  input  logic                     c_flags_ie,
  input  logic [JC_W-1:0]          c_jump_cond,
  input  logic                     c_mem_access,
  input  logic                     c_mem_we,
  input  logic [FLAG_CNT-1:0]      i_alu_flags,
  input  logic                     i_jmp_predict,
  output logic                     o_pc_inc,
  output logic                     o_pc_load,
  output logic                     o_flush,
  output logic [FLAG_CNT-1:0]      o_flags,
  input  logic                     i_wb_valid,
  input  logic [REGNO-1:0]         i_wb_ie,
  input  logic                     i_next_ready,
  output logic                     o_submit,
  output logic [REGNO-1:0]         o_reg_ie,
  output logic                     o_mem_access,
  output logic                     o_mem_we,
  output logic                     o_l_fwd,
  output logic                     o_r_fwd
);

  localparam int CNT_W = $clog2(SB_DEPTH + 1);
  localparam int CC_W  = JC_W - 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SB_DEPTH);

  localparam int F_C = 0;
  localparam int F_Z = 1;
  localparam int F_N = 2;
  localparam int F_O = 3;
  localparam int F_P = 4;

  localparam logic [CC_W-1:0] CC_ALW = CC_W'(0);
  localparam logic [CC_W-1:0] CC_C   = CC_W'(1);
  localparam logic [CC_W-1:0] CC_Z   = CC_W'(2);
  localparam logic [CC_W-1:0] CC_N   = CC_W'(3);
  localparam logic [CC_W-1:0] CC_GT  = CC_W'(4);
  localparam logic [CC_W-1:0] CC_LE  = CC_W'(5);
  localparam logic [CC_W-1:0] CC_NN  = CC_W'(6);
  localparam logic [CC_W-1:0] CC_NZ  = CC_W'(7);
  localparam logic [CC_W-1:0] CC_O   = CC_W'(8);
  localparam logic [CC_W-1:0] CC_P   = CC_W'(9);

  logic [CNT_W-1:0]    cnt_q [REGNO];
  logic [CNT_W-1:0]    cnt_d [REGNO];
  logic [FLAG_CNT-1:0] flags_q, flags_d;
  logic                flush_q, flush_d;
  logic                submit_q, submit_d;
  logic [REGNO-1:0]    reg_ie_q, reg_ie_d;
  logic                mem_access_q, mem_access_d;
  logic                mem_we_q, mem_we_d;

  logic             l_fwd_s, r_fwd_s;
  logic             l_haz_s, r_haz_s, full_s, hazard_s;
  logic             ready_s, fire_s, jv_s, taken_s;
  logic [REGNO-1:0] inc_s, dec_s;

  // A source at count 1 retiring this very cycle can take the writeback bus instead of stalling.
`ifdef EXEC_FWD_EN
  assign l_fwd_s = c_l_use & (cnt_q[c_l_sel] == CNT_ONE) & i_wb_valid & i_wb_ie[c_l_sel];
  assign r_fwd_s = c_r_use & (cnt_q[c_r_sel] == CNT_ONE) & i_wb_valid & i_wb_ie[c_r_sel];
`else
  assign l_fwd_s = 1'b0;
  assign r_fwd_s = 1'b0;
`endif

  assign l_haz_s  = c_l_use & (cnt_q[c_l_sel] != CNT_ZERO) & ~l_fwd_s;
  assign r_haz_s  = c_r_use & (cnt_q[c_r_sel] != CNT_ZERO) & ~r_fwd_s;
  assign hazard_s = l_haz_s | r_haz_s | full_s;
  assign ready_s  = i_next_ready & ~hazard_s;
  assign fire_s   = i_submit & ~i_flush & ready_s;
  assign jv_s     = c_jump_cond[JC_W-1];
  assign inc_s    = {REGNO{fire_s}} & c_rf_ie;

  // Destination saturation and per-register retire qualification.
  always_comb begin
    full_s = 1'b0;
    dec_s  = {REGNO{1'b0}};
    for (int r = 0; r < REGNO; r++) begin
      full_s   = full_s | (c_rf_ie[r] & (cnt_q[r] == CNT_FULL));
      dec_s[r] = i_wb_valid & i_wb_ie[r] & (cnt_q[r] != CNT_ZERO);
    end
  end

  // Jump condition decode against the registered flags.
  always_comb begin
    taken_s = 1'b0;
    case (c_jump_cond[CC_W-1:0])
      CC_ALW:  taken_s = 1'b1;
      CC_C:    taken_s = flags_q[F_C];
      CC_Z:    taken_s = flags_q[F_Z];
      CC_N:    taken_s = flags_q[F_N];
      CC_GT:   taken_s = ~(flags_q[F_N] | flags_q[F_Z]);
      CC_LE:   taken_s = flags_q[F_N] | flags_q[F_Z];
      CC_NN:   taken_s = ~flags_q[F_N];
      CC_NZ:   taken_s = ~flags_q[F_Z];
      CC_O:    taken_s = flags_q[F_O];
      CC_P:    taken_s = flags_q[F_P];
      default: taken_s = 1'b0;
    endcase
  end

  // Scoreboard next state: a matched issue and retire cancel out.
  always_comb begin
    for (int r = 0; r < REGNO; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_s[r] & ~dec_s[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec_s[r] & ~inc_s[r]) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  // Flag register, mispredict pulse and next-stage control word.
  always_comb begin
    flags_d      = flags_q;
    reg_ie_d     = reg_ie_q;
    mem_access_d = mem_access_q;
    mem_we_d     = mem_we_q;
    flush_d      = fire_s & jv_s & (taken_s ^ i_jmp_predict);
    submit_d     = fire_s;
    if (fire_s & c_flags_ie) begin
      flags_d = i_alu_flags;
    end else begin
      flags_d = flags_q;
    end
    if (fire_s) begin
      reg_ie_d     = c_rf_ie;
      mem_access_d = c_mem_access;
      mem_we_d     = c_mem_we;
    end else begin
      reg_ie_d     = reg_ie_q;
      mem_access_d = mem_access_q;
      mem_we_d     = mem_we_q;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < REGNO; r++) begin
        cnt_q[r] <= CNT_ZERO;
      end
      flags_q      <= {FLAG_CNT{1'b0}};
      flush_q      <= 1'b0;
      submit_q     <= 1'b0;
      reg_ie_q     <= {REGNO{1'b0}};
      mem_access_q <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      for (int r = 0; r < REGNO; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      flags_q      <= flags_d;
      flush_q      <= flush_d;
      submit_q     <= submit_d;
      reg_ie_q     <= reg_ie_d;
      mem_access_q <= mem_access_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign o_ready      = ready_s;
  assign o_pc_load    = fire_s & jv_s & taken_s;
  assign o_pc_inc     = fire_s & ~(jv_s & taken_s);
  assign o_flush      = flush_q;
  assign o_flags      = flags_q;
  assign o_submit     = submit_q;
  assign o_reg_ie     = reg_ie_q;
  assign o_mem_access = mem_access_q;
  assign o_mem_we     = mem_we_q;
  assign o_l_fwd      = l_fwd_s;
  assign o_r_fwd      = r_fwd_s;

endmodule

// File: tb/tb_exec_issue_ctl.sv
// Directed bench for exec_issue_ctl with a per-cycle reference model of the issue rules.
module tb_exec_issue_ctl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_submit, i_flush, o_ready;
  logic [2:0] c_l_sel, c_r_sel;
  logic       c_l_use, c_r_use;
  logic [7:0] c_rf_ie;
  logic       c_flags_ie;
  logic [4:0] c_jump_cond;
  logic       c_mem_access, c_mem_we;
  logic [4:0] i_alu_flags;
  logic       i_jmp_predict;
  logic       o_pc_inc, o_pc_load, o_flush;
  logic [4:0] o_flags;
  logic       i_wb_valid;
  logic [7:0] i_wb_ie;
  logic       i_next_ready;
  logic       o_submit;
  logic [7:0] o_reg_ie;
  logic       o_mem_access, o_mem_we, o_l_fwd, o_r_fwd;

  int total = 0;
  int bad   = 0;

  exec_issue_ctl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_submit(i_submit), .i_flush(i_flush),
    .o_ready(o_ready), .c_l_sel(c_l_sel), .c_r_sel(c_r_sel), .c_l_use(c_l_use),
    .c_r_use(c_r_use), .c_rf_ie(c_rf_ie), .c_flags_ie(c_flags_ie),
    .c_jump_cond(c_jump_cond), .c_mem_access(c_mem_access), .c_mem_we(c_mem_we),
    .i_alu_flags(i_alu_flags), .i_jmp_predict(i_jmp_predict), .o_pc_inc(o_pc_inc),
    .o_pc_load(o_pc_load), .o_flush(o_flush), .o_flags(o_flags),
    .i_wb_valid(i_wb_valid), .i_wb_ie(i_wb_ie), .i_next_ready(i_next_ready),
    .o_submit(o_submit), .o_reg_ie(o_reg_ie), .o_mem_access(o_mem_access),
    .o_mem_we(o_mem_we), .o_l_fwd(o_l_fwd), .o_r_fwd(o_r_fwd)
  );

  always #5 i_clk = ~i_clk;

  // Reference model state
  int         m_cnt [8];
  logic [4:0] m_flags;
  logic       m_flush, m_submit, m_acc, m_we;
  logic [7:0] m_reg_ie;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_taken(input logic [4:0] cc, input logic [4:0] f);
    bit c, z, n, o, p;
    c = f[0]; z = f[1]; n = f[2]; o = f[3]; p = f[4];
    if (!cc[4]) return 1'b0;
    case (int'(cc[3:0]))
      0: return 1'b1;
      1: return c;
      2: return z;
      3: return n;
      4: return !(n || z);
      5: return n || z;
      6: return !n;
      7: return !z;
      8: return o;
      9: return p;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit src_fwd(input logic rd, input logic [2:0] sel);
`ifdef EXEC_FWD_EN
    return rd && (m_cnt[sel] == 1) && i_wb_valid && i_wb_ie[sel];
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    bit stall;
    stall = (c_l_use && m_cnt[c_l_sel] > 0 && !src_fwd(c_l_use, c_l_sel)) ||
            (c_r_use && m_cnt[c_r_sel] > 0 && !src_fwd(c_r_use, c_r_sel));
    for (int r = 0; r < 8; r++)
      if (c_rf_ie[r] && m_cnt[r] >= 2) stall = 1'b1;
    return i_next_ready && !stall;
  endfunction

  function automatic bit m_fire();
    return i_submit && !i_flush && m_ready();
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    bit f, tk;
    if (!i_rst_n) begin
      for (int r = 0; r < 8; r++) m_cnt[r] = 0;
      m_flags = 5'h00; m_flush = 1'b0; m_submit = 1'b0;
      m_reg_ie = 8'h00; m_acc = 1'b0; m_we = 1'b0;
    end else begin
      f  = m_fire();
      tk = m_taken(c_jump_cond, m_flags);
      for (int r = 0; r < 8; r++) begin
        if (f && c_rf_ie[r]) m_cnt[r] = m_cnt[r] + 1;
        if (i_wb_valid && i_wb_ie[r] && m_cnt[r] > 0 && !(f && c_rf_ie[r])) m_cnt[r] = m_cnt[r] - 1;
        else if (i_wb_valid && i_wb_ie[r] && f && c_rf_ie[r] && m_cnt[r] > 1) m_cnt[r] = m_cnt[r] - 1;
      end
      m_flush  = f && c_jump_cond[4] && (tk != i_jmp_predict);
      if (f && c_flags_ie) m_flags = i_alu_flags;
      m_submit = f;
      if (f) begin
        m_reg_ie = c_rf_ie; m_acc = c_mem_access; m_we = c_mem_we;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge i_clk) begin
    bit f, jt;
    f  = m_fire();
    jt = c_jump_cond[4] && m_taken(c_jump_cond, m_flags);
    chk("ready", o_ready, m_ready());
    chk("pc_load", o_pc_load, f && jt);
    chk("pc_inc", o_pc_inc, f && !jt);
    chk("l_fwd", o_l_fwd, src_fwd(c_l_use, c_l_sel));
    chk("r_fwd", o_r_fwd, src_fwd(c_r_use, c_r_sel));
    chk("flags", o_flags, m_flags);
    chk("flush", o_flush, m_flush);
    chk("submit", o_submit, m_submit);
    chk("reg_ie", o_reg_ie, m_reg_ie);
    chk("mem_access", o_mem_access, m_acc);
    chk("mem_we", o_mem_we, m_we);
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear();
    i_submit = 1'b0; i_flush = 1'b0; c_l_sel = 3'd0; c_r_sel = 3'd0;
    c_l_use = 1'b0; c_r_use = 1'b0; c_rf_ie = 8'h00; c_flags_ie = 1'b0;
    c_jump_cond = 5'h00; c_mem_access = 1'b0; c_mem_we = 1'b0;
    i_alu_flags = 5'h00; i_jmp_predict = 1'b0; i_wb_valid = 1'b0; i_wb_ie = 8'h00;
    i_next_ready = 1'b1;
  endtask

  logic [4:0] fpat [8];

  initial begin
    fpat = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h06, 5'h08, 5'h10, 5'h1F};
    i_rst_n = 1'b0;
    clear();
    // Reset with an instruction presented
    i_submit = 1'b1; c_rf_ie = 8'h01; c_flags_ie = 1'b1; i_alu_flags = 5'h1F;
    cyc(); cyc();
    @(negedge i_clk);
    chk("rst_submit", o_submit, 1'b0);
    chk("rst_flags", o_flags, 5'h00);
    chk("rst_flush", o_flush, 1'b0);
    cyc();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("first_pc_inc", o_pc_inc, 1'b1);
    cyc();
    clear(); i_submit = 1'b1; c_rf_ie = 8'h04; i_wb_valid = 1'b1; i_wb_ie = 8'h01;
    @(negedge i_clk);
    chk("first_submit", o_submit, 1'b1);
    chk("first_flags", o_flags, 5'h1F);
    chk("first_reg_ie", o_reg_ie, 8'h01);
    cyc();
    // RAW on r2, left operand
    clear(); i_submit = 1'b1; c_l_sel = 3'd2; c_l_use = 1'b1;
    @(negedge i_clk);
    chk("raw_stall", o_ready, 1'b0);
    chk("raw_pc_inc", o_pc_inc, 1'b0);
    cyc();
    i_wb_valid = 1'b1; i_wb_ie = 8'h04;
    @(negedge i_clk);
`ifdef EXEC_FWD_EN
    chk("raw_fwd_ready", o_ready, 1'b1);
    chk("raw_fwd_sel", o_l_fwd, 1'b1);
    cyc();
`else
    chk("raw_wb_ready", o_ready, 1'b0);
    cyc();
    i_wb_valid = 1'b0; i_wb_ie = 8'h00;
    @(negedge i_clk);
    chk("raw_after_wb", o_ready, 1'b1);
    cyc();
`endif
    // RAW on r5, right operand
    clear(); i_submit = 1'b1; c_rf_ie = 8'h20; cyc();
    clear(); i_submit = 1'b1; c_r_sel = 3'd5; c_r_use = 1'b1; i_wb_valid = 1'b1; i_wb_ie = 8'h20; cyc();
    clear(); i_submit = 1'b1; c_r_sel = 3'd5; c_r_use = 1'b1; cyc();
    // r3: concurrent issue+retire, then saturation
    clear(); i_submit = 1'b1; c_rf_ie = 8'h08; cyc();
    i_wb_valid = 1'b1; i_wb_ie = 8'h08; cyc();
    i_wb_valid = 1'b0; i_wb_ie = 8'h00; cyc();
    @(negedge i_clk);
    chk("sb_full", o_ready, 1'b0);
    cyc(); cyc();
    clear(); i_wb_valid = 1'b1; i_wb_ie = 8'h08; cyc(); cyc();
    i_wb_ie = 8'hFF; cyc();
    clear(); i_submit = 1'b1; c_l_use = 1'b1; c_l_sel = 3'd3;
    @(negedge i_clk);
    chk("sb_drained", o_ready, 1'b1);
    cyc();
    // Mispredict on Z
    clear(); i_submit = 1'b1; c_flags_ie = 1'b1; i_alu_flags = 5'h02; cyc();
    clear(); i_submit = 1'b1; c_jump_cond = 5'b10010; i_jmp_predict = 1'b0;
    @(negedge i_clk);
    chk("mp_pc_load", o_pc_load, 1'b1);
    chk("mp_pc_inc", o_pc_inc, 1'b0);
    cyc();
    clear();
    @(negedge i_clk);
    chk("mp_flush", o_flush, 1'b1);
    cyc();
    i_submit = 1'b1; c_jump_cond = 5'b10010; i_jmp_predict = 1'b1;
    @(negedge i_clk);
    chk("mp_flush_pulse", o_flush, 1'b0);
    cyc();
    clear();
    @(negedge i_clk);
    chk("pred_ok_flush", o_flush, 1'b0);
    cyc();
    // Sweep all condition codes against assorted flag patterns
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 32; c++) begin
        clear(); i_submit = 1'b1; c_flags_ie = 1'b1; i_alu_flags = fpat[k]; cyc();
        clear(); i_submit = 1'b1; c_jump_cond = 5'(c); i_jmp_predict = 1'($urandom_range(0, 1)); cyc();
      end
    end
    // Killed instruction
    clear(); i_submit = 1'b1; c_flags_ie = 1'b1; i_alu_flags = 5'h02; cyc();
    clear(); i_submit = 1'b1; i_flush = 1'b1; c_rf_ie = 8'h01; c_flags_ie = 1'b1; i_alu_flags = 5'h1F; cyc();
    clear(); i_submit = 1'b1; c_l_use = 1'b1; c_l_sel = 3'd0;
    @(negedge i_clk);
    chk("kill_submit", o_submit, 1'b0);
    chk("kill_flags", o_flags, 5'h02);
    chk("kill_no_cnt", o_ready, 1'b1);
    cyc();
    // Backpressure
    clear(); i_next_ready = 1'b0; i_submit = 1'b1; c_rf_ie = 8'h02; c_mem_access = 1'b1; c_mem_we = 1'b1;
    @(negedge i_clk);
    chk("bp_ready", o_ready, 1'b0);
    chk("bp_pc_inc", o_pc_inc, 1'b0);
    cyc();
    @(negedge i_clk);
    chk("bp_submit", o_submit, 1'b0);
    chk("bp_hold_acc", o_mem_access, 1'b0);
    cyc();
    i_next_ready = 1'b1; cyc();
    clear();
    @(negedge i_clk);
    chk("bp_issue", o_submit, 1'b1);
    chk("bp_reg_ie", o_reg_ie, 8'h02);
    chk("bp_acc", o_mem_access, 1'b1);
    chk("bp_we", o_mem_we, 1'b1);
    cyc();
    @(negedge i_clk);
    chk("bp_single", o_submit, 1'b0);
    chk("bp_hold_reg", o_reg_ie, 8'h02);
    cyc();
    // Reset mid-operation
    i_submit = 1'b1; c_rf_ie = 8'h01; c_mem_access = 1'b1; cyc();
    clear();
    #3 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_submit", o_submit, 1'b0);
    chk("mid_rst_reg_ie", o_reg_ie, 8'h00);
    chk("mid_rst_acc", o_mem_access, 1'b0);
    cyc();
    i_rst_n = 1'b1;
    i_submit = 1'b1; c_l_use = 1'b1; c_l_sel = 3'd0; c_r_use = 1'b1; c_r_sel = 3'd1;
    @(negedge i_clk);
    chk("mid_rst_forgot", o_ready, 1'b1);
    cyc();
    clear(); cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_issue_ctl.md
Name: exec_issue_ctl

Overview:
Parametrised issue/control unit for the execute stage. It holds a per-register pending-write scoreboard, stalls on RAW hazards, owns the ALU flag register, resolves conditional jumps against the fetch-stage prediction, and registers the control word for the next pipeline stage. It sits between decode and the memory/writeback stages; the ALU, register file and PC stay outside it.

Parameters:
REGNO, 8, number of architectural registers
SB_DEPTH, 2, maximum in-flight writes per register (downstream stages before writeback)
FLAG_CNT, 5, ALU flag width; bit order C=0, Z=1, N=2, O=3, P=4
JC_W, 5, jump condition code width; bit JC_W-1 is the jump-valid bit

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_submit  in  1  decode presents an instruction
i_flush  in  1  kill the presented instruction
o_ready  out  1  stage can accept this cycle
c_l_sel, c_r_sel  in  $clog2(REGNO) each  source register selects
c_l_use, c_r_use  in  1 each  source is actually read
c_rf_ie  in  REGNO  one-hot destination mask (0 = none)
c_flags_ie  in  1  update the flag register
c_jump_cond  in  JC_W  jump condition code
c_mem_access, c_mem_we  in  1 each  memory control, passed through
i_alu_flags  in  FLAG_CNT  flags from the external ALU
i_jmp_predict  in  1  fetch predicted taken
o_pc_inc, o_pc_load  out  1 each  PC control for this cycle
o_flush  out  1  registered mispredict flush
o_flags  out  FLAG_CNT  flag register
i_wb_valid  in  1  writeback occurs this cycle
i_wb_ie  in  REGNO  writeback register mask
i_next_ready  in  1  next stage ready
o_submit  out  1  next-stage valid
o_reg_ie  out  REGNO  registered destination mask
o_mem_access, o_mem_we  out  1 each  registered memory control
o_l_fwd, o_r_fwd  out  1 each  operand forward select; constant 0 without EXEC_FWD_EN

Behaviour:
- Reset (async, i_rst_n=0): all scoreboard counters 0, o_flags 0, o_flush 0, o_submit 0, o_reg_ie 0, o_mem_access 0, o_mem_we 0.
- Scoreboard: one counter per register, width $clog2(SB_DEPTH+1).
  - On fire, counter[r] increments for every r in c_rf_ie.
  - When i_wb_valid=1, counter[r] decrements for every r in i_wb_ie.
  - Increment and decrement of the same register in one cycle leaves it unchanged.
  - A decrement at 0 is ignored (no wrap).
- hazard = (c_l_use & cnt[c_l_sel]!=0) | (c_r_use & cnt[c_r_sel]!=0) | any(c_rf_ie & cnt==SB_DEPTH).
- o_ready = i_next_ready & ~hazard (combinational).
- valid = i_submit & ~i_flush. fire = valid & o_ready.
- Flags: o_flags <= i_alu_flags on fire & c_flags_ie.
- Jump decode uses registered o_flags. Codes with the valid bit set:
  - 10000 always; 10001 C; 10010 Z; 10011 N; 10100 ~(N|Z); 10101 N|Z; 10110 ~N; 10111 ~Z; 11000 O; 11001 P.
  - Any other code gives taken=0.
- jv = c_jump_cond[JC_W-1].
- o_pc_load = fire & jv & taken. o_pc_inc = fire & ~(jv & taken). Both 0 while stalled.
- o_flush <= fire & jv & (taken ^ i_jmp_predict). It is a one-cycle pulse and does not clear the scoreboard; downstream in-flight writes still retire.
- Output register: on fire, load o_reg_ie, o_mem_access, o_mem_we and set o_submit=1. Otherwise o_submit=0 and the data fields hold. Latency is 1 cycle.
- Stall: decode holds its inputs; no state changes except scoreboard decrements.
- Reset mid-operation: everything returns to reset values immediately; pending writes are forgotten.

Optional Feature:
EXEC_FWD_EN
- Defined: a source is not a hazard when its cnt==1 and i_wb_valid & i_wb_ie[sel] in the same cycle. The matching o_l_fwd/o_r_fwd is then 1, selecting the writeback bus; that instruction issues with no stall.
- Undefined: o_l_fwd=o_r_fwd=0, and the stall persists until the counter reaches 0 (one extra cycle).

Test Plan:
- Reset with instruction presented: i_rst_n=0 -> o_submit=0, o_flags=0, o_flush=0, counters 0. Release -> first fire gives o_submit=1 next cycle.
- RAW stall: issue rf_ie=8'h04, then c_l_sel=2, c_l_use=1 -> o_ready=0. Assert i_wb_valid, i_wb_ie=8'h04 -> issues one cycle later, or the same cycle with EXEC_FWD_EN and o_l_fwd=1.
- Simultaneous issue and writeback to r3 with cnt[3]=1 -> cnt[3] stays 1. Two more issues to r3 with SB_DEPTH=2 -> the second stalls.
- Mispredict: o_flags Z=1, cond 10010, predict=0 -> o_pc_load=1, o_flush=1 for exactly one cycle. Same with predict=1 -> o_flush=0.
- Flushed input: i_submit=1, i_flush=1, c_rf_ie=8'h01, c_flags_ie=1 -> no counter change, flags hold, o_submit=0.
- Backpressure: i_next_ready=0 -> o_ready=0, o_pc_inc=0, outputs hold. Ready returns -> single issue.
